// File: rtl/swap_mutator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// swap_mutator : copies a parent genome, then applies LFSR-driven gene swaps.
// Optional SWAP_DEBUG_EN adds debug_* ports. Rev 1.0
// ---------------------------------------------------------------------------
module swap_mutator #(
  parameter int GENE_W     = 5,
  parameter int NUM_GENES  = 30,
  parameter int IDX_W      = 5,
  parameter int SWAP_CNT_W = 2,
  parameter int RETRY_MAX  = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [31:0]                 prg_seed,
  input  logic [GENE_W*NUM_GENES-1:0] parent,
`ifdef SWAP_DEBUG_EN
  output logic [2:0]                  debug_state,
  output logic [IDX_W-1:0]            debug_idx0,
  output logic [IDX_W-1:0]            debug_idx1,
  output logic [SWAP_CNT_W:0]         debug_swaps_left,
  output logic [3:0]                  debug_retry,
`endif
  output logic [GENE_W*NUM_GENES-1:0] mutant,
  output logic                        busy,
  output logic                        done
);

  localparam logic [31:0]         LFSR_TAPS   = 32'h8020_0003;
  localparam logic [IDX_W:0]      NUM_GENES_W = (IDX_W+1)'(NUM_GENES);
  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(NUM_GENES - 1);
  localparam logic [3:0]          RETRY_LIM   = 4'(RETRY_MAX);
  localparam logic [SWAP_CNT_W:0] ONE_SWAP    = (SWAP_CNT_W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DRAW_CNT = 3'd1,
    S_DRAW_IDX = 3'd2,
    S_SWAP     = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t                        state_q, state_d;
  logic [GENE_W*NUM_GENES-1:0]   mutant_q, mutant_d;
  logic [31:0]                   lfsr_q, lfsr_d;
  logic [SWAP_CNT_W:0]           swaps_left_q, swaps_left_d;
  logic [3:0]                    retry_q, retry_d;
  logic [IDX_W-1:0]              idx0_q, idx0_d;
  logic [IDX_W-1:0]              idx1_q, idx1_d;

  logic [31:0]       lfsr_step;
  logic [IDX_W-1:0]  c0, c1;
  logic              draw_ok;
  logic [GENE_W-1:0] gene0, gene1;

  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
  assign c0        = lfsr_q[IDX_W-1:0];
  assign c1        = lfsr_q[2*IDX_W-1:IDX_W];
  assign draw_ok   = (c0 != c1) && ({1'b0, c0} < NUM_GENES_W) && ({1'b0, c1} < NUM_GENES_W);
  assign gene0     = mutant_q[int'(idx0_q)*GENE_W +: GENE_W];
  assign gene1     = mutant_q[int'(idx1_q)*GENE_W +: GENE_W];

  always_comb begin
    state_d      = state_q;
    mutant_d     = mutant_q;
    lfsr_d       = lfsr_q;
    swaps_left_d = swaps_left_q;
    retry_d      = retry_q;
    idx0_d       = idx0_q;
    idx1_d       = idx1_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mutant_d = parent;
          // An all-zero state would lock the LFSR, so seed 0 maps to 1.
          lfsr_d   = (prg_seed == 32'd0) ? 32'd1 : prg_seed;
          state_d  = S_DRAW_CNT;
        end
      end
      S_DRAW_CNT: begin
        swaps_left_d = {1'b0, lfsr_q[SWAP_CNT_W-1:0]} + ONE_SWAP;
        retry_d      = 4'd0;
        lfsr_d       = lfsr_step;
        state_d      = S_DRAW_IDX;
      end
      S_DRAW_IDX: begin
        lfsr_d = lfsr_step;
        if (draw_ok) begin
          idx0_d  = c0;
          idx1_d  = c1;
          state_d = S_SWAP;
        end else if (retry_q == RETRY_LIM) begin
          idx0_d  = '0;
          idx1_d  = LAST_IDX;
          state_d = S_SWAP;
        end else begin
          retry_d = retry_q + 4'd1;
        end
      end
      S_SWAP: begin
        mutant_d[int'(idx0_q)*GENE_W +: GENE_W] = gene1;
        mutant_d[int'(idx1_q)*GENE_W +: GENE_W] = gene0;
        swaps_left_d = swaps_left_q - ONE_SWAP;
        retry_d      = 4'd0;
        state_d      = (swaps_left_q == ONE_SWAP) ? S_DONE : S_DRAW_IDX;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      mutant_q     <= '0;
      lfsr_q       <= 32'd1;
      swaps_left_q <= '0;
      retry_q      <= 4'd0;
      idx0_q       <= '0;
      idx1_q       <= '0;
    end else begin
      state_q      <= state_d;
      mutant_q     <= mutant_d;
      lfsr_q       <= lfsr_d;
      swaps_left_q <= swaps_left_d;
      retry_q      <= retry_d;
      idx0_q       <= idx0_d;
      idx1_q       <= idx1_d;
    end
  end

  assign mutant = mutant_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

`ifdef SWAP_DEBUG_EN
  assign debug_state      = state_q;
  assign debug_idx0       = idx0_q;
  assign debug_idx1       = idx1_q;
  assign debug_swaps_left = swaps_left_q;
  assign debug_retry      = retry_q;
`endif

endmodule

`default_nettype wire
